// File: rtl/dmem_pkg.sv
// =============================================================================
// Module   : dmem_pkg
// Brief    : Shared encodings, FSM state type and reset image for dmem_banked_ws.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

package dmem_pkg;

    localparam logic [1:0] DMEM_SZ_BYTE = 2'b00;
    localparam logic [1:0] DMEM_SZ_HALF = 2'b01;
    localparam logic [1:0] DMEM_SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    localparam logic [31:0] DMEM_RST_WORD0 = 32'd5;
    localparam logic [31:0] DMEM_RST_WORD1 = 32'd6;
    localparam logic [31:0] DMEM_RST_WORD2 = 32'd7;
    localparam int          DMEM_RST_WORDS = 3;

    localparam int DMEM_LAT_MIN = 1;
    localparam int DMEM_LAT_MAX = 15;
    localparam int DMEM_CNT_W   = 4;

    function automatic logic [31:0] dmem_rst_word(input int idx);
        case (idx)
            0:       return DMEM_RST_WORD0;
            1:       return DMEM_RST_WORD1;
            default: return DMEM_RST_WORD2;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_lane_align.sv
// =============================================================================
// Module   : dmem_lane_align
// Brief    : Little-endian lane steering, store merge and load extension.
//            Alignment checking is compiled in with DMEM_ALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] cur_word_i,
    output logic [31:0] wr_word_o,
    output logic [3:0]  byte_en_o,
    output logic [31:0] rd_data_o,
    output logic        misalign_o
);

    logic        w_is_byte;
    logic        w_is_half;
    logic [1:0]  w_lane;
    logic [7:0]  w_sel_byte;
    logic [15:0] w_sel_half;
    logic [31:0] w_wr_rep;

    always_comb begin
        w_is_byte = (size_i == DMEM_SZ_BYTE);
        w_is_half = (size_i == DMEM_SZ_HALF);
`ifdef DMEM_ALIGN_CHECK_EN
        w_lane     = addr_lo_i;
        misalign_o = (w_is_half && addr_lo_i[0]) ||
                     (!w_is_byte && !w_is_half && (addr_lo_i != 2'b00));
`else
        // Legacy build snaps the lane to the access size instead of flagging it.
        w_lane     = w_is_byte ? addr_lo_i :
                     (w_is_half ? {addr_lo_i[1], 1'b0} : 2'b00);
        misalign_o = 1'b0;
`endif
        w_sel_byte = cur_word_i[{w_lane, 3'b000} +: 8];
        w_sel_half = w_lane[1] ? cur_word_i[31:16] : cur_word_i[15:0];

        rd_data_o = 32'd0;
        byte_en_o = 4'b0000;
        w_wr_rep  = wdata_i;
        if (!misalign_o) begin
            if (w_is_byte) begin
                rd_data_o = {{24{w_sel_byte[7] & ~unsigned_i}}, w_sel_byte};
                byte_en_o = 4'b0001 << w_lane;
                w_wr_rep  = {4{wdata_i[7:0]}};
            end else if (w_is_half) begin
                rd_data_o = {{16{w_sel_half[15] & ~unsigned_i}}, w_sel_half};
                byte_en_o = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wr_rep  = {2{wdata_i[15:0]}};
            end else begin
                rd_data_o = cur_word_i;
                byte_en_o = 4'b1111;
            end
        end

        for (int b = 0; b < 4; b++) begin
            wr_word_o[8*b +: 8] = byte_en_o[b] ? w_wr_rep[8*b +: 8] : cur_word_i[8*b +: 8];
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_banked_ws.sv
// =============================================================================
// Module   : dmem_banked_ws
// Brief    : Byte-addressable data memory with LATENCY wait states behind a
//            valid/ready request and one-cycle response. Macro: DMEM_ALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module dmem_banked_ws
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       wdata,
    output logic              rsp_valid,
    output logic [31:0]       rdata,
    output logic              misalign_err,
    output logic              busy
);

    localparam int WA_W  = ADDR_W - 2;
    localparam int DEPTH = 2 ** WA_W;

    dmem_state_e           state_q;
    logic [DMEM_CNT_W-1:0] cnt_q;
    logic                  we_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [31:0]           wdata_q;
    logic                  rsp_valid_q;
    logic [31:0]           rdata_q;
    logic                  mis_q;

    logic [31:0]           w_words [DEPTH];
    logic [WA_W-1:0]       w_waddr;
    logic [31:0]           w_cur;
    logic [31:0]           w_wr_word;
    logic [3:0]            w_be;
    logic [31:0]           w_rd_data;
    logic                  w_mis;
    logic                  w_wr_en;

    assign w_waddr = addr_q[ADDR_W-1:2];
    assign w_cur   = w_words[w_waddr];
    assign w_wr_en = (state_q == ST_RESP) && we_q && (|w_be);

    dmem_lane_align u_lane (
        .size_i     (size_q),
        .addr_lo_i  (addr_q[1:0]),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .cur_word_i (w_cur),
        .wr_word_o  (w_wr_word),
        .byte_en_o  (w_be),
        .rd_data_o  (w_rd_data),
        .misalign_o (w_mis)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            size_q      <= DMEM_SZ_WORD;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'd0;
            mis_q       <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        addr_q  <= address;
                        wdata_q <= wdata;
                        cnt_q   <= DMEM_CNT_W'(LATENCY - 1);
                        state_q <= (LATENCY == DMEM_LAT_MIN) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == DMEM_CNT_W'(1)) begin
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    rsp_valid_q <= 1'b1;
                    rdata_q     <= we_q ? 32'd0 : w_rd_data;
                    mis_q       <= w_mis;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Only the first words carry a reset image; the rest stay reset-free.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        logic [31:0] word_q;
        if (i < DMEM_RST_WORDS) begin : g_rst
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    word_q <= dmem_rst_word(i);
                end else if (w_wr_en && (w_waddr == WA_W'(i))) begin
                    word_q <= w_wr_word;
                end
            end
        end else begin : g_norst
            always_ff @(posedge clock) begin
                if (w_wr_en && (w_waddr == WA_W'(i))) begin
                    word_q <= w_wr_word;
                end
            end
        end
        assign w_words[i] = word_q;
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign rsp_valid    = rsp_valid_q;
    assign rdata        = rdata_q;
    assign misalign_err = mis_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_banked_ws.sv
// =============================================================================
// Module   : tb_dmem_banked_ws
// Brief    : Scoreboard bench for dmem_banked_ws (LATENCY=2 main, LATENCY=3 pacing).
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_dmem_banked_ws;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [8:0]  address;
    logic [31:0] wdata;
    logic        req_ready, rsp_valid, misalign_err, busy;
    logic [31:0] rdata;

    logic        req_valid3, req_we3, req_unsigned3;
    logic [1:0]  req_size3;
    logic [8:0]  address3;
    logic [31:0] wdata3;
    logic        req_ready3, rsp_valid3, misalign_err3, busy3;
    logic [31:0] rdata3;

    dmem_banked_ws #(.ADDR_W(9), .LATENCY(2)) dut (
        .clock(clk), .reset(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .address(address), .wdata(wdata), .rsp_valid(rsp_valid), .rdata(rdata),
        .misalign_err(misalign_err), .busy(busy)
    );

    dmem_banked_ws #(.ADDR_W(9), .LATENCY(3)) dut3 (
        .clock(clk), .reset(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_we(req_we3), .req_size(req_size3), .req_unsigned(req_unsigned3),
        .address(address3), .wdata(wdata3), .rsp_valid(rsp_valid3), .rdata(rdata3),
        .misalign_err(misalign_err3), .busy(busy3)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_mis = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_mis++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
            end else begin
                e = sb.pop_front();
                chk({e.name, "_rdata"}, rdata, e.rdata);
                chk({e.name, "_err"}, 32'(misalign_err), 32'(e.err));
                chk({e.name, "_latency"}, 32'(cyc - e.acc), 32'd2);
            end
        end
    end

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [8:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input bit push, input string name);
        int   t;
        exp_t e;
        t = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (req_ready !== 1'b1) begin
            n_vec++;
            n_mis++;
            $display("FAIL %s_ready_timeout: got req_ready=%b expected 1", name, req_ready);
            return;
        end
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        address      = a;
        wdata        = wd;
        req_valid    = 1'b1;
        if (push) begin
            e.rdata = exp_rd;
            e.err   = exp_err;
            e.acc   = cyc + 1;
            e.name  = name;
            sb.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1);
    end

    initial begin
        int t;
        int a;
        int ph;
        req_valid = 1'b0; req_we = 1'b0; req_size = DMEM_SZ_WORD; req_unsigned = 1'b0;
        address = '0; wdata = '0;
        req_valid3 = 1'b0; req_we3 = 1'b0; req_size3 = DMEM_SZ_WORD; req_unsigned3 = 1'b0;
        address3 = '0; wdata3 = '0;

        repeat (2) @(negedge clk);
        chk("rst_ready",  32'(req_ready),    32'd1);
        chk("rst_busy",   32'(busy),         32'd0);
        chk("rst_rsp",    32'(rsp_valid),    32'd0);
        chk("rst_rdata",  rdata,             32'd0);
        chk("rst_err",    32'(misalign_err), 32'd0);
        rst_n = 1'b1;

        issue(1'b0, DMEM_SZ_WORD, 1'b0, 9'h004, 32'd0, 32'd6, 1'b0, 1'b1, "ldw_4");
        repeat (4) @(negedge clk);
        chk("rdata_hold", rdata, 32'd6);

        issue(1'b1, DMEM_SZ_BYTE, 1'b0, 9'h009, 32'h000000AB, 32'd0, 1'b0, 1'b1, "stb_9");
        issue(1'b0, DMEM_SZ_WORD, 1'b0, 9'h008, 32'd0, 32'h0000AB07, 1'b0, 1'b1, "ldw_8");
        issue(1'b0, DMEM_SZ_BYTE, 1'b0, 9'h009, 32'd0, 32'hFFFFFFAB, 1'b0, 1'b1, "ldb_s_9");
        issue(1'b0, DMEM_SZ_BYTE, 1'b1, 9'h009, 32'd0, 32'h000000AB, 1'b0, 1'b1, "ldb_u_9");
        issue(1'b0, DMEM_SZ_BYTE, 1'b0, 9'h008, 32'd0, 32'h00000007, 1'b0, 1'b1, "ldb_s_8");

        issue(1'b1, DMEM_SZ_WORD, 1'b0, 9'h00C, 32'hDEADBEEF, 32'd0, 1'b0, 1'b1, "stw_c");
        issue(1'b1, DMEM_SZ_HALF, 1'b0, 9'h00E, 32'h00008001, 32'd0, 1'b0, 1'b1, "sth_e");
        issue(1'b0, DMEM_SZ_HALF, 1'b0, 9'h00E, 32'd0, 32'hFFFF8001, 1'b0, 1'b1, "ldh_s_e");
        issue(1'b0, DMEM_SZ_HALF, 1'b1, 9'h00C, 32'd0, 32'h0000BEEF, 1'b0, 1'b1, "ldh_u_c");
        issue(1'b0, DMEM_SZ_WORD, 1'b0, 9'h00C, 32'd0, 32'h8001BEEF, 1'b0, 1'b1, "ldw_c");
        issue(1'b0, DMEM_SZ_BYTE, 1'b0, 9'h00F, 32'd0, 32'hFFFFFF80, 1'b0, 1'b1, "ldb_s_f");
        issue(1'b0, DMEM_SZ_BYTE, 1'b1, 9'h00E, 32'd0, 32'h00000001, 1'b0, 1'b1, "ldb_u_e");
        issue(1'b0, 2'b11,        1'b0, 9'h004, 32'd0, 32'd6,        1'b0, 1'b1, "ldsz3_4");

`ifdef DMEM_ALIGN_CHECK_EN
        issue(1'b0, DMEM_SZ_WORD, 1'b0, 9'h006, 32'd0, 32'd0, 1'b1, 1'b1, "ldw_mis_6");
        issue(1'b1, DMEM_SZ_HALF, 1'b0, 9'h005, 32'h0000FFFF, 32'd0, 1'b1, 1'b1, "sth_mis_5");
`else
        issue(1'b0, DMEM_SZ_WORD, 1'b0, 9'h006, 32'd0, 32'd6, 1'b0, 1'b1, "ldw_snap_6");
`endif
        issue(1'b0, DMEM_SZ_WORD, 1'b0, 9'h004, 32'd0, 32'd6, 1'b0, 1'b1, "ldw_after_mis");

        issue(1'b1, DMEM_SZ_WORD, 1'b0, 9'h010, 32'hCAFEF00D, 32'd0, 1'b0, 1'b1, "stw_10");
        issue(1'b1, DMEM_SZ_WORD, 1'b0, 9'h010, 32'h12345678, 32'd0, 1'b0, 1'b0, "stw_abort");
        rst_n = 1'b0;
        #1;
        chk("abort_busy",  32'(busy),      32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        issue(1'b0, DMEM_SZ_WORD, 1'b0, 9'h010, 32'd0, 32'hCAFEF00D, 1'b0, 1'b1, "ldw_10_kept");
        issue(1'b0, DMEM_SZ_WORD, 1'b0, 9'h000, 32'd0, 32'd5, 1'b0, 1'b1, "ldw_0_rst");
        issue(1'b0, DMEM_SZ_WORD, 1'b0, 9'h008, 32'd0, 32'd7, 1'b0, 1'b1, "ldw_8_rst");

        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0", sb.size());
        end

        // LATENCY=3 instance with req_valid held: one accept every 4 cycles.
        @(negedge clk);
        req_valid3 = 1'b1;
        a = cyc + 1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            ph = (cyc - a) % 4;
            chk("lat3_busy",  32'(busy3),      (ph != 3) ? 32'd1 : 32'd0);
            chk("lat3_rsp",   32'(rsp_valid3), (ph == 3) ? 32'd1 : 32'd0);
            chk("lat3_ready", 32'(req_ready3), (ph == 3) ? 32'd1 : 32'd0);
            if (ph == 3) chk("lat3_rdata", rdata3, 32'd5);
        end
        req_valid3 = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
